// File: rtl/cycle_controller.sv
// -----------------------------------------------------------------------------
// cycle_controller
//
// Multi-cycle instruction sequencer for a small load/store core. One
// instruction is walked through FETCH -> DECODE -> EXECUTE [-> MEMORY]
// [-> WRITEBACK] and back to FETCH. The pc, register-file and data-memory
// strobes are issued from the current state and the instruction class that
// was captured in DECODE. An illegal instruction parks the FSM in HALT until
// reset.
//
// Ports
//   clk                    in   1   single clock, rising edge
//   rst_n                  in   1   asynchronous active-low reset
//   start                  in   1   level, leaves IDLE when high
//   imem_ready             in   1   instruction memory data valid
//   dmem_ready             in   1   data memory load data valid
//   dec_reg_write_enable   in   1   decoder: register write request
//   dec_data_write_enable  in   1   decoder: data memory write request
//   dec_reg_write_select   in   1   decoder: 1 = ALU result, 0 = memory data
//   dec_branch             in   2   decoder: branch code, nonzero = branch
//   branch_cond            in   1   ALU comparison result for the branch
//   imem_req               out  1   instruction fetch request
//   ir_load                out  1   latch fetched instruction into IR
//   reg_write_enable       out  1   register file write strobe
//   data_write_enable      out  1   data memory write strobe
//   pc_inc                 out  1   advance PC to next instruction
//   pc_branch              out  1   load PC with branch target
//   state                  out  3   current FSM state
//   halted                 out  1   sticky illegal-instruction indicator
//   retired                out  16  retired instruction count (wraps)
// -----------------------------------------------------------------------------
module cycle_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        dec_reg_write_enable,
  input  logic        dec_data_write_enable,
  input  logic        dec_reg_write_select,
  input  logic [1:0]  dec_branch,
  input  logic        branch_cond,
  output logic        imem_req,
  output logic        ir_load,
  output logic        reg_write_enable,
  output logic        data_write_enable,
  output logic        pc_inc,
  output logic        pc_branch,
  output logic [2:0]  state,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_UNUSED    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } class_t;

  state_t      r_state;
  state_t      w_next_state;
  class_t      r_class;
  class_t      w_dec_class;
  logic [15:0] r_retired;
  logic        w_retire;

  // Raw class flags straight from the decoder.
  logic        w_is_branch;
  logic        w_is_alu;
  logic        w_is_load;
  logic        w_is_store;
  logic [2:0]  w_class_cnt;

  assign w_is_branch = (dec_branch != 2'd0);
  assign w_is_alu    = dec_reg_write_select & dec_reg_write_enable;
  assign w_is_load   = ~dec_reg_write_select & dec_reg_write_enable;
  assign w_is_store  = dec_data_write_enable;
  assign w_class_cnt = {2'b00, w_is_branch} + {2'b00, w_is_alu}
                     + {2'b00, w_is_load}   + {2'b00, w_is_store};

  // Exactly one flag set gives a legal class; zero or several is CLS_NONE,
  // which DECODE treats as illegal.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_dec_class = CLS_NONE;
    if (w_class_cnt == 3'd1) begin
      if (w_is_branch)     w_dec_class = CLS_BRANCH;
      else if (w_is_alu)   w_dec_class = CLS_ALU;
      else if (w_is_load)  w_dec_class = CLS_LOAD;
      else                 w_dec_class = CLS_STORE;
    end
  end

  // State, class and retire counter. The class is sampled only in DECODE so
  // the decoder inputs are free to change for the rest of the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_class   <= CLS_NONE;
      r_retired <= 16'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values, independent of statement order.
      r_state <= w_next_state;
      if (r_state == ST_DECODE) begin
        r_class <= w_dec_class;
      end
      // Natural 16-bit overflow gives the required wrap to zero.
      r_retired <= r_retired + {15'd0, w_retire};
    end
  end

  // Next-state and strobe generation.
  always_comb begin
    w_next_state      = r_state;
    w_retire          = 1'b0;
    imem_req          = 1'b0;
    ir_load           = 1'b0;
    reg_write_enable  = 1'b0;
    data_write_enable = 1'b0;
    pc_inc            = 1'b0;
    pc_branch         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
        if (imem_ready) w_next_state = ST_DECODE;
      end

      ST_DECODE: begin
        if (w_dec_class == CLS_NONE) w_next_state = ST_HALT;
        else                         w_next_state = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        case (r_class)
          CLS_BRANCH: begin
            pc_branch    = branch_cond;
            pc_inc       = ~branch_cond;
            w_retire     = 1'b1;
            w_next_state = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: w_next_state = ST_MEMORY;
          CLS_ALU:             w_next_state = ST_WRITEBACK;
          // Unreachable: DECODE never lets CLS_NONE through.
          default:             w_next_state = ST_IDLE;
        endcase
      end

      ST_MEMORY: begin
        if (r_class == CLS_STORE) begin
          data_write_enable = 1'b1;
          pc_inc            = 1'b1;
          w_retire          = 1'b1;
          w_next_state      = ST_FETCH;
        end else if (r_class == CLS_LOAD) begin
          // Load waits silently; the register write happens in WRITEBACK.
          if (dmem_ready) w_next_state = ST_WRITEBACK;
        end else begin
          w_next_state = ST_IDLE;
        end
      end

      ST_WRITEBACK: begin
        reg_write_enable = 1'b1;
        pc_inc           = 1'b1;
        w_retire         = 1'b1;
        w_next_state     = ST_FETCH;
      end

      ST_HALT: begin
        w_next_state = ST_HALT;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign state   = r_state;
  // HALT is only left through reset, so deriving the flag from the state
  // keeps it sticky without a separate flop.
  assign halted  = (r_state == ST_HALT);
  assign retired = r_retired;

endmodule

// File: tb/tb_cycle_controller.sv
// -----------------------------------------------------------------------------
// tb_cycle_controller
//
// Drives randomized instruction streams into cycle_controller. For each
// instruction the bench builds the expected per-cycle timeline (state,
// strobes, retire count) from the instruction class and the chosen memory
// wait lengths, and compares the DUT against it on the falling edge.
// Decoder inputs, start and the memory readies are scrambled in every cycle
// where they must not matter.
// -----------------------------------------------------------------------------
module tb_cycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_ready;
  logic        dmem_ready;
  logic        dec_reg_write_enable;
  logic        dec_data_write_enable;
  logic        dec_reg_write_select;
  logic [1:0]  dec_branch;
  logic        branch_cond;
  logic        imem_req;
  logic        ir_load;
  logic        reg_write_enable;
  logic        data_write_enable;
  logic        pc_inc;
  logic        pc_branch;
  logic [2:0]  state;
  logic        halted;
  logic [15:0] retired;

  cycle_controller dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .imem_ready            (imem_ready),
    .dmem_ready            (dmem_ready),
    .dec_reg_write_enable  (dec_reg_write_enable),
    .dec_data_write_enable (dec_data_write_enable),
    .dec_reg_write_select  (dec_reg_write_select),
    .dec_branch            (dec_branch),
    .branch_cond           (branch_cond),
    .imem_req              (imem_req),
    .ir_load               (ir_load),
    .reg_write_enable      (reg_write_enable),
    .data_write_enable     (data_write_enable),
    .pc_inc                (pc_inc),
    .pc_branch             (pc_branch),
    .state                 (state),
    .halted                (halted),
    .retired               (retired)
  );

  always #5 clk = ~clk;

  // Strobe bundle: {imem_req, ir_load, reg_we, data_we, pc_inc, pc_branch}
  logic [5:0] w_strobes;
  assign w_strobes = {imem_req, ir_load, reg_write_enable, data_write_enable,
                      pc_inc, pc_branch};

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_IREQ = 6'b100000;
  localparam logic [5:0] S_IRL  = 6'b010000;
  localparam logic [5:0] S_RWE  = 6'b001000;
  localparam logic [5:0] S_DWE  = 6'b000100;
  localparam logic [5:0] S_INC  = 6'b000010;
  localparam logic [5:0] S_BR   = 6'b000001;

  localparam logic [2:0] E_IDLE = 3'd0, E_FETCH = 3'd1, E_DECODE = 3'd2,
                         E_EXEC = 3'd3, E_MEM = 3'd4, E_WB = 3'd5,
                         E_HALT = 3'd6;

  typedef enum int {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_ILLEGAL} kind_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_retired;
  string       phase = "init";

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s @%0t: got=0x%0h expected=0x%0h",
               phase, tag, $time, got, exp);
    end
  endtask

  task automatic check_all(input logic [2:0] es, input logic [5:0] estr);
    check("state",   {29'd0, state},     {29'd0, es});
    check("strobes", {26'd0, w_strobes}, {26'd0, estr});
    check("retired", {16'd0, retired},   {16'd0, exp_retired});
    check("halted",  {31'd0, halted},    {31'd0, (es == E_HALT)});
  endtask

  // One clock: inputs already set; compare at negedge, then advance.
  task automatic cyc(input logic [2:0] es, input logic [5:0] estr,
                     input bit retire);
    @(negedge clk);
    check_all(es, estr);
    @(posedge clk);
    #1;
    if (retire) exp_retired = exp_retired + 16'd1;
  endtask

  task automatic scramble();
    start                 = 1'($urandom);
    imem_ready            = 1'($urandom);
    dmem_ready            = 1'($urandom);
    dec_reg_write_enable  = 1'($urandom);
    dec_data_write_enable = 1'($urandom);
    dec_reg_write_select  = 1'($urandom);
    dec_branch            = 2'($urandom);
    branch_cond           = 1'($urandom);
  endtask

  task automatic set_dec(input kind_t k);
    dec_reg_write_enable  = 1'b0;
    dec_data_write_enable = 1'b0;
    dec_reg_write_select  = 1'($urandom);
    dec_branch            = 2'd0;
    case (k)
      K_ALU:    begin dec_reg_write_enable = 1'b1; dec_reg_write_select = 1'b1; end
      K_LOAD:   begin dec_reg_write_enable = 1'b1; dec_reg_write_select = 1'b0; end
      K_STORE:  dec_data_write_enable = 1'b1;
      K_BRANCH: dec_branch = 2'($urandom_range(1, 3));
      default: begin
        // Illegal: no class, or two classes at once.
        case ($urandom_range(0, 2))
          0: dec_reg_write_select = 1'b0;
          1: begin dec_reg_write_enable = 1'b1; dec_data_write_enable = 1'b1; end
          default: begin dec_branch = 2'($urandom_range(1, 3)); dec_data_write_enable = 1'b1; end
        endcase
      end
    endcase
  endtask

  // Runs one instruction starting in FETCH; ends back in FETCH (or HALT).
  task automatic run_instr(input kind_t k, input int iw, input int dw,
                           input bit bc);
    for (int i = 0; i < iw; i++) begin
      scramble(); imem_ready = 1'b0; cyc(E_FETCH, S_IREQ, 0);
    end
    scramble(); imem_ready = 1'b1; cyc(E_FETCH, S_IREQ | S_IRL, 0);
    scramble(); set_dec(k);        cyc(E_DECODE, S_NONE, 0);
    if (k == K_ILLEGAL) begin
      for (int i = 0; i < 10; i++) begin
        scramble(); cyc(E_HALT, S_NONE, 0);
      end
      return;
    end
    scramble(); branch_cond = bc;
    if (k == K_BRANCH) begin
      cyc(E_EXEC, bc ? S_BR : S_INC, 1);
      return;
    end
    cyc(E_EXEC, S_NONE, 0);
    case (k)
      K_LOAD: begin
        for (int i = 0; i < dw; i++) begin
          scramble(); dmem_ready = 1'b0; cyc(E_MEM, S_NONE, 0);
        end
        scramble(); dmem_ready = 1'b1; cyc(E_MEM, S_NONE, 0);
        scramble(); cyc(E_WB, S_RWE | S_INC, 1);
      end
      K_STORE: begin scramble(); cyc(E_MEM, S_DWE | S_INC, 1); end
      default: begin scramble(); cyc(E_WB, S_RWE | S_INC, 1); end
    endcase
  endtask

  // Asserts reset mid-cycle and checks its effect before the next edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    exp_retired = 16'd0;
    check_all(E_IDLE, S_NONE);
    @(posedge clk);
    #1;
    check_all(E_IDLE, S_NONE);
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      scramble(); start = 1'b0; cyc(E_IDLE, S_NONE, 0);
    end
  endtask

  task automatic kick();
    scramble(); start = 1'b1; cyc(E_IDLE, S_NONE, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    scramble();
    start = 1'b0;
    exp_retired = 16'd0;
    #1 rst_n = 1'b0;
    #1;
    phase = "reset";
    check_all(E_IDLE, S_NONE);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(3);

    phase = "alu";
    kick();
    run_instr(K_ALU, 0, 0, 1'b0);
    phase = "load_wait3";
    run_instr(K_LOAD, 0, 3, 1'b0);
    phase = "beq_taken";
    run_instr(K_BRANCH, 0, 0, 1'b1);
    phase = "blt_not_taken";
    run_instr(K_BRANCH, 0, 0, 1'b0);
    phase = "store";
    run_instr(K_STORE, 0, 0, 1'b0);

    phase = "random";
    for (int n = 0; n < 60; n++) begin
      run_instr(kind_t'($urandom_range(0, 3)), $urandom_range(0, 3),
                $urandom_range(0, 4), 1'($urandom));
    end

    // Counter wrap: preset to 0xFFFF during a non-retiring fetch cycle.
    phase = "wrap";
    force dut.r_retired = 16'hFFFF;
    exp_retired = 16'hFFFF;
    scramble(); imem_ready = 1'b0; cyc(E_FETCH, S_IREQ, 0);
    release dut.r_retired;
    run_instr(K_STORE, 0, 0, 1'b0);
    run_instr(K_STORE, 1, 0, 1'b0);

    phase = "illegal";
    run_instr(K_ILLEGAL, 0, 0, 1'b0);
    async_reset();
    idle_cycles(2);

    phase = "reset_in_fetch";
    kick();
    scramble(); imem_ready = 1'b0; cyc(E_FETCH, S_IREQ, 0);
    scramble(); imem_ready = 1'b0;
    async_reset();
    idle_cycles(5);

    phase = "reset_in_load_wait";
    kick();
    scramble(); imem_ready = 1'b1; cyc(E_FETCH, S_IREQ | S_IRL, 0);
    scramble(); set_dec(K_LOAD);   cyc(E_DECODE, S_NONE, 0);
    scramble();                    cyc(E_EXEC, S_NONE, 0);
    scramble(); dmem_ready = 1'b0; cyc(E_MEM, S_NONE, 0);
    scramble(); dmem_ready = 1'b0;
    async_reset();
    idle_cycles(5);

    phase = "after_reset";
    kick();
    run_instr(K_ALU, 2, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cycle_controller.md
CYCLE_CONTROLLER -- requirements
Module: cycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; its ports SHALL be listed clock and reset first, as follows.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  level; begin execution from IDLE.
REQ-005 imem_ready  input  1  instruction memory returns valid instruction this cycle.
REQ-006 dmem_ready  input  1  data memory load data valid this cycle.
REQ-007 dec_reg_write_enable  input  1  decoder register write-enable request.
REQ-008 dec_data_write_enable  input  1  decoder data-memory write request.
REQ-009 dec_reg_write_select  input  1  decoder select: 1 = ALU result, 0 = memory data.
REQ-010 dec_branch  input  2  decoder branch code: 0 = no jump, nonzero = BEQ/BLT.
REQ-011 branch_cond  input  1  ALU comparison result for the current branch.
REQ-012 imem_req  output  1  request instruction fetch.
REQ-013 ir_load  output  1  latch the fetched instruction into the instruction register.
REQ-014 reg_write_enable  output  1  gated register-file write strobe.
REQ-015 data_write_enable  output  1  gated data-memory write strobe.
REQ-016 pc_inc  output  1  advance PC to the next instruction.
REQ-017 pc_branch  output  1  load PC with the branch target.
REQ-018 state  output  3  current FSM state encoding.
REQ-019 halted  output  1  sticky illegal-instruction halt indicator.
REQ-020 retired  output  16  count of retired instructions.

Function
REQ-021 State encoding SHALL be: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6; code 7 SHALL transition to IDLE on the next edge.
REQ-022 Instruction classes SHALL be decoded in DECODE: branch = dec_branch!=0; alu = dec_reg_write_select & dec_reg_write_enable; load = !dec_reg_write_select & dec_reg_write_enable; store = dec_data_write_enable; illegal = none of these, or more than one of these.
REQ-023 IDLE: the FSM SHALL move to FETCH when start=1; otherwise it SHALL remain in IDLE; start SHALL be ignored in every other state.
REQ-024 FETCH: imem_req SHALL be 1; ir_load SHALL equal imem_ready (combinational); the FSM SHALL move to DECODE on imem_ready=1, else hold in FETCH with no timeout.
REQ-025 DECODE: illegal SHALL go to HALT; all other classes SHALL go to EXECUTE.
REQ-026 EXECUTE, branch class: exactly one of pc_branch (branch_cond=1) or pc_inc (branch_cond=0) SHALL pulse for one cycle, retired SHALL increment, next state SHALL be FETCH.
REQ-027 EXECUTE, load or store class: next state SHALL be MEMORY; EXECUTE, alu class: next state SHALL be WRITEBACK.
REQ-028 MEMORY, store: data_write_enable=1 and pc_inc=1 for exactly one cycle, retired SHALL increment, next state SHALL be FETCH.
REQ-029 MEMORY, load: the FSM SHALL wait for dmem_ready=1, then go to WRITEBACK; no strobe SHALL be asserted while waiting.
REQ-030 WRITEBACK: reg_write_enable=1 and pc_inc=1 for one cycle, retired SHALL increment, next state SHALL be FETCH.
REQ-031 The class SHALL be captured in a register at DECODE; later-cycle changes on the dec_* inputs SHALL NOT alter sequencing.
REQ-032 HALT: halted=1; the FSM SHALL stay in HALT until reset, and all strobes SHALL be 0.
REQ-033 retired SHALL wrap from 0xFFFF to 0x0000 without saturating.
REQ-034 At most one of pc_inc and pc_branch SHALL be 1 in any cycle; reg_write_enable and data_write_enable SHALL never both be 1.
REQ-035 Zero-wait latency SHALL be: alu 4 cycles, store 4, load 5, branch 3, each counted from the FETCH entry edge to the FETCH re-entry edge.

Reset
REQ-036 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, halted=0, retired=0, the class register to 0, and all strobes to 0.
REQ-037 Reset asserted mid-instruction (for example MEMORY waiting on dmem_ready) SHALL abort with no strobe emitted; after release, the FSM SHALL stay in IDLE until start=1.

Verification
REQ-038 Add: start=1, imem_ready=1, decoder alu class -> states 1,2,3,5,1; one reg_write_enable+pc_inc pulse; retired=1.
REQ-039 Load with dmem_ready low 3 cycles -> MEMORY held 4 cycles, then WRITEBACK reg_write_enable pulse; total 8 cycles; retired=1.
REQ-040 BEQ branch_cond=1 then BLT branch_cond=0 -> pc_branch pulse, then pc_inc pulse; never both; retired=2.
REQ-041 Illegal (all dec_* inputs 0) -> HALT at cycle 3, halted=1; start and imem_ready toggled for 10 cycles -> no strobe.
REQ-042 Preload retired=0xFFFF via 65535 stores -> next store gives retired=0x0000.
REQ-043 rst_n low asynchronously during FETCH with imem_ready=0 -> state=0 before the next clock edge; after release with start=0 for 5 cycles -> stays IDLE.
